// File: rtl/xres_sequencer.sv
// External/software reset sequencer: synchronizes and optionally filters the XRES pad,
// then holds and stretches a registered system reset, recording what caused it.
module xres_sequencer #(
   parameter int FILT_CYCLES    = 16,
   parameter int STRETCH_CYCLES = 1024,
   parameter int CNT_W          = 16
) (
   input  logic       wb_clk_i,
   input  logic       wb_rst_i,
   input  logic       xres_h_n_i,
   input  logic       sw_rst_req_i,
   input  logic       filt_en_i,
   output logic       pad_inp_sel_o,
   output logic       sys_rst_o,
   output logic       sys_rst_n_o,
   output logic [1:0] rst_cause_o,
   output logic [1:0] state_o
);

   typedef enum logic [1:0] {
      ST_RUN     = 2'b00,
      ST_FILTER  = 2'b01,
      ST_HOLD    = 2'b10,
      ST_STRETCH = 2'b11
   } state_t;

   localparam logic [1:0] CAUSE_POR = 2'b00;
   localparam logic [1:0] CAUSE_PAD = 2'b01;
   localparam logic [1:0] CAUSE_SW  = 2'b10;

   // Both terminal counts must fit the counter, otherwise the compare would never match.
   generate
      if (FILT_CYCLES < 1 || longint'(FILT_CYCLES) >= (longint'(1) << CNT_W)) begin : g_bad_filt
         $error("xres_sequencer: FILT_CYCLES must be in [1, 2**CNT_W - 1]");
      end
      if (STRETCH_CYCLES < 1 || longint'(STRETCH_CYCLES) >= (longint'(1) << CNT_W)) begin : g_bad_stretch
         $error("xres_sequencer: STRETCH_CYCLES must be in [1, 2**CNT_W - 1]");
      end
   endgenerate

   localparam logic [CNT_W-1:0] FILT_LAST    = CNT_W'(FILT_CYCLES - 1);
   localparam logic [CNT_W-1:0] STRETCH_LAST = CNT_W'(STRETCH_CYCLES - 1);

   logic             sync1_q, sync2_q;
   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [1:0]       cause_q, cause_d;
   logic             sys_rst_q, sys_rst_d;
   logic             sys_rst_n_q;
   logic             pad_sel_q;
   logic             xs;

   assign xs = sync2_q;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      cause_d = cause_q;
      unique case (state_q)
         ST_RUN: begin
            // Pad takes priority over a simultaneous software request.
            if (!xs) begin
               if (filt_en_i) begin
                  state_d = ST_FILTER;
                  cnt_d   = '0;
               end else begin
                  state_d = ST_HOLD;
                  cause_d = CAUSE_PAD;
               end
            end else if (sw_rst_req_i) begin
               state_d = ST_STRETCH;
               cnt_d   = '0;
               cause_d = CAUSE_SW;
            end
         end
         ST_FILTER: begin
            if (xs) begin
               state_d = ST_RUN;
            end else if (cnt_q == FILT_LAST) begin
               state_d = ST_HOLD;
               cause_d = CAUSE_PAD;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_HOLD: begin
            if (xs) begin
               state_d = ST_STRETCH;
               cnt_d   = '0;
            end
         end
         ST_STRETCH: begin
            if (!xs) begin
               state_d = ST_HOLD;
            end else if (cnt_q == STRETCH_LAST) begin
               state_d = ST_RUN;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
      endcase
      sys_rst_d = (state_d == ST_HOLD) || (state_d == ST_STRETCH);
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         sync1_q     <= 1'b1;
         sync2_q     <= 1'b1;
         state_q     <= ST_STRETCH;
         cnt_q       <= '0;
         cause_q     <= CAUSE_POR;
         sys_rst_q   <= 1'b1;
         sys_rst_n_q <= 1'b0;
         pad_sel_q   <= 1'b0;
      end else begin
         sync1_q     <= xres_h_n_i;
         sync2_q     <= sync1_q;
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         cause_q     <= cause_d;
         sys_rst_q   <= sys_rst_d;
         sys_rst_n_q <= ~sys_rst_d;
         pad_sel_q   <= ~filt_en_i;
      end
   end

   assign pad_inp_sel_o = pad_sel_q;
   assign sys_rst_o     = sys_rst_q;
   assign sys_rst_n_o   = sys_rst_n_q;
   assign rst_cause_o   = cause_q;
   assign state_o       = state_q;

endmodule

// File: tb/tb_xres_sequencer.sv
// Bench for xres_sequencer: directed scenarios plus random pad/software activity,
// compared every cycle against a deadline-based reference model.
module tb_xres_sequencer;

   localparam int FILT = 4;
   localparam int STR  = 8;
   localparam int CW   = 16;

   localparam int M_RUN = 0, M_FILTER = 1, M_HOLD = 2, M_STRETCH = 3;

   logic       clk = 1'b0;
   logic       rst, pad, sw, filt;
   logic       pad_inp_sel, sys_rst, sys_rst_n;
   logic [1:0] cause, state;

   int n_tests = 0;
   int n_fail  = 0;

   // reference model: phase plus absolute edge number at which a timed phase expires
   int m_state, m_cause, m_deadline, edge_n;
   bit m_s1, m_s2, m_sel;

   xres_sequencer #(.FILT_CYCLES(FILT), .STRETCH_CYCLES(STR), .CNT_W(CW)) dut (
      .wb_clk_i     (clk),
      .wb_rst_i     (rst),
      .xres_h_n_i   (pad),
      .sw_rst_req_i (sw),
      .filt_en_i    (filt),
      .pad_inp_sel_o(pad_inp_sel),
      .sys_rst_o    (sys_rst),
      .sys_rst_n_o  (sys_rst_n),
      .rst_cause_o  (cause),
      .state_o      (state)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_edge(input bit r, input bit p, input bit s, input bit f);
      bit xs;
      edge_n++;
      xs = m_s2;
      if (r) begin
         m_state = M_STRETCH; m_deadline = edge_n + STR; m_cause = 0;
         m_s1 = 1'b1; m_s2 = 1'b1; m_sel = 1'b0;
         return;
      end
      case (m_state)
         M_RUN:
            if (!xs) begin
               if (f) begin m_state = M_FILTER; m_deadline = edge_n + FILT; end
               else begin m_state = M_HOLD; m_cause = 1; end
            end else if (s) begin
               m_state = M_STRETCH; m_deadline = edge_n + STR; m_cause = 2;
            end
         M_FILTER:
            if (xs) m_state = M_RUN;
            else if (edge_n == m_deadline) begin m_state = M_HOLD; m_cause = 1; end
         M_HOLD:
            if (xs) begin m_state = M_STRETCH; m_deadline = edge_n + STR; end
         default:
            if (!xs) m_state = M_HOLD;
            else if (edge_n == m_deadline) m_state = M_RUN;
      endcase
      m_s2 = m_s1;
      m_s1 = p;
      m_sel = !f;
   endtask

   task automatic check_all();
      bit exp_rst;
      exp_rst = (m_state == M_HOLD) || (m_state == M_STRETCH);
      chk("state",       32'(state),       32'(m_state));
      chk("cause",       32'(cause),       32'(m_cause));
      chk("sys_rst",     32'(sys_rst),     32'(exp_rst));
      chk("sys_rst_n",   32'(sys_rst_n),   32'(!exp_rst));
      chk("pad_inp_sel", 32'(pad_inp_sel), 32'(m_sel));
   endtask

   task automatic tick();
      bit r, p, s, f;
      r = rst; p = pad; s = sw; f = filt;
      @(posedge clk);
      model_edge(r, p, s, f);
      #1;
      check_all();
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   initial begin
      bit saw_filter, any_rst;
      int seg;
      edge_n = 0; m_state = M_STRETCH; m_cause = 0; m_deadline = 0;
      m_s1 = 1'b1; m_s2 = 1'b1; m_sel = 1'b0;
      rst = 1'b1; pad = 1'b1; sw = 1'b0; filt = 1'b1;

      // reset release
      ticks(3);
      chk("rst_sys_rst", 32'(sys_rst), 32'd1);
      chk("rst_sync", 32'({dut.sync1_q, dut.sync2_q}), 32'd3);
      rst = 1'b0;
      ticks(7);
      chk("rel_still_high", 32'(sys_rst), 32'd1);
      tick();
      chk("rel_fall", 32'(sys_rst), 32'd0);
      chk("rel_state", 32'(state), 32'd0);
      chk("rel_cause", 32'(cause), 32'd0);
      ticks(3);

      // glitch shorter than the filter
      saw_filter = 1'b0; any_rst = 1'b0;
      pad = 1'b0;
      for (int i = 0; i < 9; i++) begin
         if (i == 3) pad = 1'b1;
         tick();
         if (state == 2'b01) saw_filter = 1'b1;
         if (sys_rst) any_rst = 1'b1;
      end
      chk("glitch_filter_seen", 32'(saw_filter), 32'd1);
      chk("glitch_no_rst", 32'(any_rst), 32'd0);
      chk("glitch_state", 32'(state), 32'd0);
      chk("glitch_cause", 32'(cause), 32'd0);

      // qualified pad reset with filter
      pad = 1'b0;
      ticks(6);
      chk("pad_pre_rise", 32'(sys_rst), 32'd0);
      tick();
      chk("pad_rise_e7", 32'(sys_rst), 32'd1);
      ticks(13);
      pad = 1'b1;
      ticks(10);
      chk("pad_pre_fall", 32'(sys_rst), 32'd1);
      tick();
      chk("pad_fall_e11", 32'(sys_rst), 32'd0);
      chk("pad_cause", 32'(cause), 32'd1);

      // software reset pulse
      tick();
      sw = 1'b1;
      tick();
      sw = 1'b0;
      chk("sw_rise", 32'(sys_rst), 32'd1);
      chk("sw_cause", 32'(cause), 32'd2);
      ticks(7);
      chk("sw_pre_fall", 32'(sys_rst), 32'd1);
      tick();
      chk("sw_fall", 32'(sys_rst), 32'd0);

      // pad and software request together, filter off
      filt = 1'b0;
      tick();
      chk("pad_sel_on", 32'(pad_inp_sel), 32'd1);
      pad = 1'b0;
      ticks(2);
      sw = 1'b1;
      tick();
      sw = 1'b0;
      chk("both_state", 32'(state), 32'd2);
      chk("both_cause", 32'(cause), 32'd1);
      pad = 1'b1;
      ticks(12);

      // re-assert during stretch
      sw = 1'b1;
      tick();
      sw = 1'b0;
      ticks(3);
      pad = 1'b0;
      ticks(2);
      chk("reassert_pre", 32'(state), 32'd3);
      tick();
      chk("reassert_hold", 32'(state), 32'd2);
      ticks(3);
      pad = 1'b1;
      ticks(10);
      chk("reassert_stretch_hi", 32'(sys_rst), 32'd1);
      tick();
      chk("reassert_stretch_lo", 32'(sys_rst), 32'd0);

      // wb_rst_i during HOLD
      pad = 1'b0;
      ticks(4);
      chk("mid_hold", 32'(state), 32'd2);
      rst = 1'b1;
      tick();
      chk("mid_rst_state", 32'(state), 32'd3);
      chk("mid_rst_cause", 32'(cause), 32'd0);
      chk("mid_rst_sync", 32'({dut.sync1_q, dut.sync2_q}), 32'd3);
      rst = 1'b0;
      pad = 1'b1;
      ticks(12);

      // random activity
      seg = 0;
      for (int i = 0; i < 1500; i++) begin
         if (seg == 0) begin
            pad = ~pad;
            if (pad) seg = int'($urandom_range(1, 25));
            else if ($urandom_range(0, 1) == 0) seg = int'($urandom_range(1, 6));
            else seg = int'($urandom_range(5, 20));
         end
         seg--;
         sw = ($urandom_range(0, 11) == 0);
         if ($urandom_range(0, 63) == 0) filt = ~filt;
         rst = ($urandom_range(0, 299) == 0);
         tick();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/xres_sequencer.md
XRES_SEQUENCER -- requirements
Module: xres_sequencer

Interface
REQ-001 The block SHALL have exactly one clock and one reset; reset is synchronous and active-high: wb_clk_i, wb_rst_i.
REQ-002 Parameter FILT_CYCLES, default 16, is the number of cycles the synchronized pad level must stay low before it counts as a reset.
REQ-003 Parameter STRETCH_CYCLES, default 1024, is the number of cycles sys_rst_o stays high after a reset source is released.
REQ-004 Parameter CNT_W, default 16, is the width of the shared counter.
REQ-005 Port wb_clk_i, input, 1 bit: system clock.
REQ-006 Port wb_rst_i, input, 1 bit: synchronous active-high reset.
REQ-007 Port xres_h_n_i, input, 1 bit: external reset pin, level-shifted from the XRES pad, asynchronous to wb_clk_i, active-low.
REQ-008 Port sw_rst_req_i, input, 1 bit: software reset request, level-sampled.
REQ-009 Port filt_en_i, input, 1 bit: enables the internal glitch filter.
REQ-010 Port pad_inp_sel_o, output, 1 bit: registered copy of ~filt_en_i; drives the pad input-select so the pad filter is used when the internal filter is off.
REQ-011 Port sys_rst_o, output, 1 bit: registered system reset, active-high.
REQ-012 Port sys_rst_n_o, output, 1 bit: registered inverse of sys_rst_o.
REQ-013 Port rst_cause_o, output, 2 bits: 00 = power-on/wb_rst_i, 01 = external pad, 10 = software; 11 is never driven.
REQ-014 Port state_o, output, 2 bits: 00 = RUN, 01 = FILTER, 10 = HOLD, 11 = STRETCH.

Function
REQ-015 xres_h_n_i SHALL pass through a 2-flop synchronizer (reset value 1) before use; xs denotes the second flop.
REQ-016 RUN: sys_rst_o=0; if xs=0 and filt_en_i=1, go to FILTER with cnt=0; if xs=0 and filt_en_i=0, go to HOLD with cause=01; else if sw_rst_req_i=1, go to STRETCH with cnt=0 and cause=10.
REQ-017 When the pad condition and sw_rst_req_i occur in the same cycle in RUN, the pad condition SHALL win.
REQ-018 FILTER: sys_rst_o=0; if xs=1, return to RUN (glitch rejected, cause unchanged); else if cnt==FILT_CYCLES-1, go to HOLD with cause=01; else cnt+1.
REQ-019 HOLD: sys_rst_o=1; stay while xs=0; on xs=1, go to STRETCH with cnt=0; sw_rst_req_i is ignored.
REQ-020 STRETCH: sys_rst_o=1; if xs=0, go to HOLD (the stretch restarts on the next release); else if cnt==STRETCH_CYCLES-1, go to RUN; else cnt+1; sw_rst_req_i is ignored.
REQ-021 sys_rst_o SHALL be registered from the next-state value, so it changes on the same edge as the state transition.
REQ-022 Latency, filter off: sys_rst_o SHALL rise on the 3rd rising edge after xres_h_n_i falls.
REQ-023 Latency, filter on: sys_rst_o SHALL rise on edge 3+FILT_CYCLES after xres_h_n_i falls.
REQ-024 Release: sys_rst_o SHALL fall on edge 3+STRETCH_CYCLES after xres_h_n_i rises.
REQ-025 Software reset: sys_rst_o SHALL rise on the edge that samples the request in RUN and fall STRETCH_CYCLES edges later.
REQ-026 If sw_rst_req_i is still high on return to RUN, a new software reset SHALL start.
REQ-027 rst_cause_o SHALL hold its last value until a new cause is recorded.
REQ-028 The counter SHALL never wrap; FILT_CYCLES and STRETCH_CYCLES SHALL each be at least 1 and below 2^CNT_W, checked at elaboration.

Reset
REQ-029 While wb_rst_i=1, the block SHALL hold: state=STRETCH, cnt=0, sys_rst_o=1, sys_rst_n_o=0, rst_cause_o=00, pad_inp_sel_o=0, both sync flops=1.
REQ-030 wb_rst_i asserted in any state, including mid-HOLD, SHALL override all activity at the next edge.
REQ-031 After wb_rst_i falls, sys_rst_o SHALL fall STRETCH_CYCLES edges later, provided xs stays 1.

Verification (bench parameters: FILT_CYCLES=4, STRETCH_CYCLES=8)
REQ-032 Reset release: wb_rst_i=1 for 3 cycles then 0, pad high -> sys_rst_o=1 for exactly 8 edges, then 0; cause=00; state goes 11 then 00.
REQ-033 Glitch: filt_en_i=1, xres_h_n_i low for 3 cycles -> sys_rst_o stays 0; state goes 01 then 00; cause unchanged.
REQ-034 Valid pad reset: filt_en_i=1, xres_h_n_i low for 20 cycles -> sys_rst_o rises at edge 7 after the fall and falls at edge 11 after the rise; cause=01.
REQ-035 Software reset: 1-cycle sw_rst_req_i pulse in RUN -> sys_rst_o high for 8 edges; cause=10. Request in the same cycle as pad low with filt_en_i=0 -> state 10; cause=01.
REQ-036 Re-assert: pad low at STRETCH cnt=5 -> state 10; after release, a full 8-cycle stretch.
REQ-037 Reset mid-operation: wb_rst_i pulsed during HOLD -> state 11, cause 00 on the next edge; sync flops read 1.
